// File: rtl/vga_sync_gen_pkg.sv
// Purpose: shared 640x480@60 VGA timing constants and coordinate helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a. Renderers import this package for active-area bounds.
package vga_sync_gen_pkg;

  // Horizontal timing, in pixels.
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 800

  // Vertical timing, in lines.
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 525

  // Inclusive sync pulse windows.
  localparam int HS_START = H_ACTIVE + H_FP;                    // 656
  localparam int HS_END   = HS_START + H_SYNC - 1;              // 751
  localparam int VS_START = V_ACTIVE + V_FP;                    // 490
  localparam int VS_END   = VS_START + V_SYNC - 1;              // 491

  typedef logic [9:0] coord_t;

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

  // True when lo <= v <= hi.
  function automatic logic in_window(input coord_t v, input int lo, input int hi);
    return (v >= coord_t'(lo)) && (v <= coord_t'(hi));
  endfunction

endpackage

// File: rtl/vga_pix_en.sv
// Purpose: divides clk into a one-clk pixel-enable strobe every CLK_DIV clks.
// Latency: first strobe CLK_DIV clks after reset release; strobe is registered.
// Backpressure: none, free-running.
// Ports: clk (system clock), rst (async active-low), pix_en (strobe out).
module vga_pix_en #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] r_div_cnt;
  logic          r_pix_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= '0;
      r_pix_en  <= 1'b0;
    end else begin
      // Strobe lands in the cycle after the counter sits on its last value.
      r_pix_en  <= (r_div_cnt == DIV_LAST);
      r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DW'(1);
    end
  end

  assign pix_en = r_pix_en;

endmodule

// File: rtl/vga_sync_gen.sv
// Purpose: 640x480@60 VGA timing: h/v counters, registered sync, coords, strobes.
// Latency: outputs lag the counters by one pixel; loaded on the pix_en edge.
// Backpressure: none, free-running; outputs hold between pix_en strobes.
// Ports: clk, rst (async active-low); pix_en, hs, vs, x, y, video_on,
//        line_start, frame_start, frame_cnt (all registered outputs).
// Build option: VGA_FRAME_CNT_EN enables the 16-bit frame counter; otherwise
//        frame_cnt is tied to zero and the port is kept.
import vga_sync_gen_pkg::*;

module vga_sync_gen #(
  parameter int   CLK_DIV = 4,
  parameter logic HS_POL  = 1'b0,
  parameter logic VS_POL  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pix_en,
  output logic        hs,
  output logic        vs,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        video_on,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  logic   w_pix_en;
  coord_t r_h_cnt, r_v_cnt;
  logic   w_h_last, w_v_last;
  logic   w_hs, w_vs, w_video_on, w_line_first, w_frame_first;

  coord_t r_x, r_y;
  logic   r_hs, r_vs, r_video_on, r_line_start, r_frame_start;

  vga_pix_en #(.CLK_DIV(CLK_DIV)) u_pix_en (
    .clk    (clk),
    .rst    (rst),
    .pix_en (w_pix_en)
  );

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_pix_en) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + coord_t'(1);
      end else begin
        r_h_cnt <= r_h_cnt + coord_t'(1);
      end
    end
  end

  // Decode of the pre-increment counters; registered below on the same edge.
  assign w_hs          = in_window(r_h_cnt, HS_START, HS_END) ? HS_POL : ~HS_POL;
  assign w_vs          = in_window(r_v_cnt, VS_START, VS_END) ? VS_POL : ~VS_POL;
  assign w_video_on    = (r_h_cnt < coord_t'(H_ACTIVE)) && (r_v_cnt < coord_t'(V_ACTIVE));
  assign w_line_first  = (r_h_cnt == '0);
  assign w_frame_first = w_line_first && (r_v_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x           <= '0;
      r_y           <= '0;
      r_hs          <= ~HS_POL;
      r_vs          <= ~VS_POL;
      r_video_on    <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (w_pix_en) begin
      r_x           <= r_h_cnt;
      r_y           <= r_v_cnt;
      r_hs          <= w_hs;
      r_vs          <= w_vs;
      r_video_on    <= w_video_on;
      r_line_start  <= w_line_first;
      r_frame_start <= w_frame_first;
    end else begin
      // Strobes last only the single clk after their loading edge.
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_cnt <= '0;
    end else if (w_pix_en && w_frame_first) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`else
  assign frame_cnt = '0;
`endif

  assign pix_en      = w_pix_en;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign x           = r_x;
  assign y           = r_y;
  assign video_on    = r_video_on;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Purpose: self-checking bench for vga_sync_gen (CLK_DIV=4, active-low syncs).
// Latency: n/a.
// Backpressure: n/a.
module tb_vga_sync_gen;

  localparam int   DIV = 4;
  localparam logic HSP = 1'b0;
  localparam logic VSP = 1'b0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pix_en, hs, vs, video_on, line_start, frame_start;
  logic [9:0]  x, y;
  logic [15:0] frame_cnt;

  vga_sync_gen #(.CLK_DIV(DIV), .HS_POL(HSP), .VS_POL(VSP)) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .hs          (hs),
    .vs          (vs),
    .x           (x),
    .y           (y),
    .video_on    (video_on),
    .line_start  (line_start),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: c = clks since reset release; (mh,mv) = next pixel to load.
  int          c, mh, mv;
  logic [9:0]  ex, ey;
  logic        evo, ehs, evs, els, efs, epix;
  logic [15:0] efc;

  typedef struct {
    int         c;
    logic       pe;
    logic [9:0] x;
    logic [9:0] y;
    logic       vo;
    logic       ls;
    logic       fs;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    c = 0; mh = 0; mv = 0;
    ex = '0; ey = '0;
    evo = 1'b0; ehs = ~HSP; evs = ~VSP;
    els = 1'b0; efs = 1'b0; epix = 1'b0;
    efc = '0;
  endtask

  task automatic check_all(input string name);
    logic [41:0] act, exp;
    act = {pix_en, hs, vs, x, y, video_on, line_start, frame_start, frame_cnt};
    exp = {epix, ehs, evs, ex, ey, evo, els, efs, efc};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s c=%0d: got pe=%b hs=%b vs=%b x=%0d y=%0d vo=%b ls=%b fs=%b fc=%0d expected pe=%b hs=%b vs=%b x=%0d y=%0d vo=%b ls=%b fs=%b fc=%0d",
               name, c, pix_en, hs, vs, x, y, video_on, line_start, frame_start, frame_cnt,
               epix, ehs, evs, ex, ey, evo, els, efs, efc);
    end
  endtask

  // One clk; model advances from the timing rules, then all outputs compared.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst) begin
      c++;
      epix = (c % DIV == 0);
      if (c > DIV && (c - 1) % DIV == 0) begin
        ex  = 10'(mh);
        ey  = 10'(mv);
        evo = (mh < 640) && (mv < 480);
        ehs = (mh >= 656 && mh <= 751) ? HSP : ~HSP;
        evs = (mv >= 490 && mv <= 491) ? VSP : ~VSP;
        els = (mh == 0);
        efs = (mh == 0) && (mv == 0);
`ifdef VGA_FRAME_CNT_EN
        if (efs) efc = efc + 16'd1;
`endif
        mh = mh + 1;
        if (mh == 800) begin
          mh = 0;
          mv = mv + 1;
          if (mv == 525) mv = 0;
        end
      end else begin
        els = 1'b0;
        efs = 1'b0;
      end
    end
    check_all("cycle");
  endtask

  // Assert reset between edges and check outputs clear with no clock edge.
  task automatic async_reset(input int dly);
    #(dly);
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
  endtask

  task automatic run_until_mh(input int h, input int v, input string name);
    int guard;
    guard = 0;
    while (!(mh == h && mv == v) && guard < 5000) begin
      step();
      guard++;
    end
    check(name, int'(guard < 5000), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard, hs_low, hs_first, hs_last, vo_low, last_x, vs_low, vs_first, vs_last;
    int last_y;
    bit done;

    tbl[0] = '{1,  1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{3,  1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{4,  1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{5,  1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{6,  1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{8,  1'b1, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{9,  1'b0, 10'd1, 10'd0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{13, 1'b0, 10'd2, 10'd0, 1'b1, 1'b0, 1'b0};

    // Reset held for 10 clks.
    rst = 1'b0;
    model_reset();
    repeat (10) step();
    check("reset_hs", int'(hs), 1);
    check("reset_vs", int'(vs), 1);
    check("reset_vo", int'(video_on), 0);
    rst = 1'b1;

    // First pixel sequence from the vector table.
    for (int i = 0; i < 8; i++) begin
      guard = 0;
      while (c < tbl[i].c && guard < 100) begin
        step();
        guard++;
      end
      check("tbl_pix_en", int'(pix_en), int'(tbl[i].pe));
      check("tbl_x", int'(x), int'(tbl[i].x));
      check("tbl_y", int'(y), int'(tbl[i].y));
      check("tbl_video_on", int'(video_on), int'(tbl[i].vo));
      check("tbl_line_start", int'(line_start), int'(tbl[i].ls));
      check("tbl_frame_start", int'(frame_start), int'(tbl[i].fs));
      if (i == 3) begin
`ifdef VGA_FRAME_CNT_EN
        check("first_frame_cnt", int'(frame_cnt), 1);
`else
        check("first_frame_cnt", int'(frame_cnt), 0);
`endif
      end
    end

    // Hsync window and blanking on line 0, then wrap to line 1.
    hs_low = 0; hs_first = -1; hs_last = -1; vo_low = 0; last_x = -1;
    guard = 0; done = 0;
    while (!done && guard < 4000) begin
      step();
      guard++;
      if (y == 10'd0) begin
        last_x = int'(x);
        if (hs == HSP) begin
          hs_low++;
          if (hs_first < 0) hs_first = int'(x);
          hs_last = int'(x);
        end
        if (!video_on) vo_low++;
      end
      if (line_start && y == 10'd1) done = 1;
    end
    check("line0_wrap_seen", int'(done), 1);
    check("hs_low_clks", hs_low, 96 * DIV);
    check("hs_first_x", hs_first, 656);
    check("hs_last_x", hs_last, 751);
    check("vo_low_clks", vo_low, 160 * DIV);
    check("line0_last_x", last_x, 799);
    check("wrap_x", int'(x), 0);
    check("wrap_frame_start", int'(frame_start), 0);

    // Random-length runs interrupted by asynchronous resets mid-cycle.
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(20, 400)) step();
      async_reset(int'($urandom_range(1, 7)));
      repeat ($urandom_range(1, 5)) step();
      rst = 1'b1;
    end

    // Jump the line counter ahead to exercise the vsync window.
    run_until_mh(10, 1, "reach_line1");
    force dut.r_v_cnt = 10'd488;
    mv = 488;
    step();
    release dut.r_v_cnt;
    vs_low = 0; vs_first = -1; vs_last = -1;
    guard = 0; done = 0;
    while (!done && guard < 25000) begin
      step();
      guard++;
      if (vs == VSP) begin
        vs_low++;
        if (vs_first < 0) vs_first = int'(y);
        vs_last = int'(y);
      end
      if (line_start && y == 10'd494) done = 1;
    end
    check("vsync_window_seen", int'(done), 1);
    check("vs_low_clks", vs_low, 1600 * DIV);
    check("vs_first_y", vs_first, 490);
    check("vs_last_y", vs_last, 491);

    // Frame wrap from the last line, with the frame counter at its top value.
    run_until_mh(10, 494, "reach_line494");
    force dut.r_v_cnt = 10'd523;
    mv = 523;
`ifdef VGA_FRAME_CNT_EN
    force dut.r_frame_cnt = 16'hFFFF;
    efc = 16'hFFFF;
`endif
    step();
    release dut.r_v_cnt;
`ifdef VGA_FRAME_CNT_EN
    release dut.r_frame_cnt;
`endif
    last_x = -1; last_y = -1;
    guard = 0; done = 0;
    while (!done && guard < 8000) begin
      step();
      guard++;
      if (frame_start) done = 1;
      else begin
        last_x = int'(x);
        last_y = int'(y);
      end
    end
    check("frame_wrap_seen", int'(done), 1);
    check("pre_wrap_x", last_x, 799);
    check("pre_wrap_y", last_y, 524);
    check("wrap_frame_x", int'(x), 0);
    check("wrap_frame_y", int'(y), 0);
    check("wrap_line_start", int'(line_start), 1);
    check("wrap_frame_cnt", int'(frame_cnt), 0);
    step();
    check("frame_start_width", int'(frame_start), 0);
    repeat (50) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
